relu_backward: RTL and testbench
================================

Name: relu_backward

Overview:
- Backward-pass counterpart of the forward ReLU stage in the CNN datapath.
- Captures a per-lane positive mask from forward activations into a mask FIFO.
- Later gates incoming gradient beats with the stored mask, in the same order, so gradient is passed only where the forward input was strictly positive.
- Sits between the loss/upstream-gradient stream and the preceding layer's weight-update logic.

Parameters:
- LANES, 4, elements per beat.
- DATA_W, 16, signed two's-complement width of each element (activation and gradient).
- DEPTH, 16, mask FIFO entries; power of two, ≥2.
- LEAK_SHIFT, 3, right-shift applied to negative-side gradient (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO and output stage.
- fwd_valid  in  1  forward activation beat valid.
- fwd_ready  out  1  mask FIFO can accept a beat.
- fwd_data  in  LANES*DATA_W  packed signed activations; lane i at [i*DATA_W +: DATA_W].
- grad_in_valid  in  1  upstream gradient beat valid.
- grad_in_ready  out  1  gradient beat accepted.
- grad_in_data  in  LANES*DATA_W  packed signed gradients.
- grad_out_valid  out  1  gated gradient valid.
- grad_out_ready  in  1  downstream accepts.
- grad_out_data  out  LANES*DATA_W  gated gradients.
- mask_count  out  $clog2(DEPTH)+1  stored mask entries.

Behaviour:
- Reset (rst_n low, async): wr_ptr, rd_ptr and count = 0; grad_out_valid = 0; grad_out_data = 0; mask_count = 0.
  - fwd_ready = 1 after reset; grad_in_ready = 0.
- Mask generation:
  - mask[i] = 1 iff signed fwd_data lane i > 0.
  - Zero and negative values give 0; the most-negative value gives 0.
- Push: fwd_valid && fwd_ready writes mask[LANES-1:0] at wr_ptr; wr_ptr increments, wrapping modulo DEPTH.
- fwd_ready = (count != DEPTH). No same-cycle bypass when full, even if a pop occurs.
- Pop/gate: grad_in_ready = (count != 0) && (!grad_out_valid || grad_out_ready).
  - On handshake, read mask at rd_ptr; rd_ptr wraps modulo DEPTH.
  - grad_out_data lane i = mask[i] ? grad lane i : 0, registered.
  - grad_out_valid = 1 on the next edge. Latency is 1 cycle.
- Empty FIFO: gradients stall (grad_in_ready = 0). They are never gated against a stale mask.
- Output hold: while grad_out_valid && !grad_out_ready, grad_out_data and grad_out_valid stay stable.
  - Output is cleared to valid = 0 when grad_out_ready is high and no new pop occurs.
- Count update:
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push only: +1. Pop only: −1.
- mask_count = count, registered.
- Flush: has priority over push and pop in the same cycle. Pointers and count go to 0, grad_out_valid goes to 0, and grad_out_data is not cleared.
- Reset mid-operation: all state is discarded immediately; no partial beat completes.
- Pure gating: no arithmetic other than the optional shift, so no overflow is possible.

Optional Feature:
- Macro: RELU_BACKWARD_LEAKY_GRAD_EN.
- Defined: lanes with mask 0 output grad >>> LEAK_SHIFT (arithmetic shift, sign-preserving; −1 >>> n stays −1). This is the leaky-ReLU derivative.
- Undefined: masked lanes output exactly 0, and LEAK_SHIFT is unused.

Decomposition:
- Package relu_pkg:
  - DATA_W and LANES defaults.
  - typedef for a lane-mask vector.
  - typedef for a packed beat.
  - function positive_mask(beat) returning the mask.
- Sub-module relu_mask_fifo: parameterised DEPTH × LANES-bit synchronous FIFO with flush, count, full and empty. The gating and output register stay in relu_backward.

Test Plan:
- Basic gating:
  - Push fwd lanes {5, −3, 0, 32767}, then grad {100, 200, 300, 400}.
  - Expect grad_out {100, 0, 0, 400} one cycle after the handshake; mask_count goes 1→0.
- Ordering and wrap:
  - Push DEPTH+4 beats with interleaved pops, using distinct masks.
  - Expect outputs gated by the masks in push order across the pointer wrap.
- Full / empty:
  - 16 pushes, no pops: fwd_ready = 0 and mask_count = 16.
  - Gradient presented with an empty FIFO: grad_in_ready = 0, no output.
- Backpressure:
  - Hold grad_out_ready = 0 for 5 cycles with a beat pending.
  - Expect output stable, grad_in_ready = 0, and no FIFO pop.
- Flush / reset:
  - flush coincident with push and pop: count = 0 next cycle, grad_out_valid = 0.
  - rst_n pulsed low mid-stream: all outputs at reset values asynchronously.
- Leaky (macro defined, LEAK_SHIFT = 3):
  - fwd {−1, −1, 2, −8} with grad {64, −64, 64, −1}.
  - Expect grad_out {8, −8, 64, −1}.

Source files
------------

// File: rtl/relu_pkg.sv
// Shared types and helpers for the ReLU backward stage: default beat geometry,
// lane-mask / packed-beat typedefs and the strictly-positive mask function.
`timescale 1ns/1ps
package relu_pkg;

  localparam int RELU_LANES  = 4;
  localparam int RELU_DATA_W = 16;

  typedef logic [RELU_LANES-1:0]             lane_mask_t;
  typedef logic [RELU_LANES*RELU_DATA_W-1:0] beat_t;

  // Strictly positive: sign bit clear and value non-zero (0 and most-negative give 0).
  function automatic lane_mask_t positive_mask(input beat_t beat);
    lane_mask_t m;
    for (int i = 0; i < RELU_LANES; i++) begin
      m[i] = !beat[i*RELU_DATA_W + RELU_DATA_W-1] && (|beat[i*RELU_DATA_W +: RELU_DATA_W]);
    end
    return m;
  endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// DEPTH x WIDTH mask FIFO with synchronous flush, occupancy count, full/empty.
// Read data is the head entry, available combinationally for same-cycle gating.
`timescale 1ns/1ps
module relu_mask_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == FULL_CNT);
  assign empty    = (r_count == '0);
  assign w_push   = push && !full && !flush;
  assign w_pop    = pop && !empty && !flush;
  assign pop_data = r_mem[r_rd_ptr];
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/relu_backward.sv
// ReLU backward stage: stores forward positive masks, gates gradient beats in order.
// Optional macro RELU_BACKWARD_LEAKY_GRAD_EN passes masked lanes as grad >>> LEAK_SHIFT.
`timescale 1ns/1ps
module relu_backward
  import relu_pkg::*;
#(
  parameter int LANES      = RELU_LANES,
  parameter int DATA_W     = RELU_DATA_W,
  parameter int DEPTH      = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      fwd_valid,
  output logic                      fwd_ready,
  input  logic [LANES*DATA_W-1:0]   fwd_data,
  input  logic                      grad_in_valid,
  output logic                      grad_in_ready,
  input  logic [LANES*DATA_W-1:0]   grad_in_data,
  output logic                      grad_out_valid,
  input  logic                      grad_out_ready,
  output logic [LANES*DATA_W-1:0]   grad_out_data,
  output logic [$clog2(DEPTH):0]    mask_count
);

`ifdef RELU_BACKWARD_LEAKY_GRAD_EN
  localparam bit LEAKY = 1'b1;
`else
  localparam bit LEAKY = 1'b0;
`endif

  logic [LANES-1:0]        w_fwd_mask;
  logic [LANES-1:0]        w_head_mask;
  logic [LANES*DATA_W-1:0] w_gated;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    r_valid;
  logic [LANES*DATA_W-1:0] r_data;

  if (LANES == RELU_LANES && DATA_W == RELU_DATA_W) begin : g_pkg_mask
    assign w_fwd_mask = positive_mask(fwd_data);
  end else begin : g_lane_mask
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_fwd_mask[gi] = !fwd_data[gi*DATA_W + DATA_W-1] && (|fwd_data[gi*DATA_W +: DATA_W]);
    end
  end

  assign fwd_ready     = !w_full;
  assign grad_in_ready = !w_empty && (!r_valid || grad_out_ready);
  assign w_push        = fwd_valid && fwd_ready;
  assign w_pop         = grad_in_valid && grad_in_ready;

  relu_mask_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LANES)
  ) u_mask_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (w_push),
    .push_data (w_fwd_mask),
    .pop       (w_pop),
    .pop_data  (w_head_mask),
    .count     (mask_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Shift kept in its own signed net so the ternary cannot turn >>> into a logical shift.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_gate
    logic signed [DATA_W-1:0] w_g;
    logic signed [DATA_W-1:0] w_leak;
    assign w_g    = grad_in_data[gi*DATA_W +: DATA_W];
    assign w_leak = w_g >>> LEAK_SHIFT;
    assign w_gated[gi*DATA_W +: DATA_W] = w_head_mask[gi] ? w_g
                                        : (LEAKY ? w_leak : {DATA_W{1'b0}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_data  <= w_gated;
    end else if (grad_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign grad_out_valid = r_valid;
  assign grad_out_data  = r_data;

endmodule

// File: tb/tb_relu_backward.sv
// Scoreboard bench for relu_backward: directed beats push expected outputs into a
// queue, an independent monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_relu_backward;

  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int CW     = $clog2(DEPTH) + 1;

`ifdef RELU_BACKWARD_LEAKY_GRAD_EN
  localparam bit LEAKY = 1'b1;
`else
  localparam bit LEAKY = 1'b0;
`endif

  logic                    clk;
  logic                    rst_n;
  logic                    flush;
  logic                    fwd_valid;
  logic                    fwd_ready;
  logic [LANES*DATA_W-1:0] fwd_data;
  logic                    grad_in_valid;
  logic                    grad_in_ready;
  logic [LANES*DATA_W-1:0] grad_in_data;
  logic                    grad_out_valid;
  logic                    grad_out_ready;
  logic [LANES*DATA_W-1:0] grad_out_data;
  logic [CW-1:0]           mask_count;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  relu_backward #(
    .LANES      (LANES),
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .LEAK_SHIFT (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .fwd_valid      (fwd_valid),
    .fwd_ready      (fwd_ready),
    .fwd_data       (fwd_data),
    .grad_in_valid  (grad_in_valid),
    .grad_in_ready  (grad_in_ready),
    .grad_in_data   (grad_in_data),
    .grad_out_valid (grad_out_valid),
    .grad_out_ready (grad_out_ready),
    .grad_out_data  (grad_out_data),
    .mask_count     (mask_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    logic [63:0] r;
    r = {d[15:0], c[15:0], b[15:0], a[15:0]};
    return r;
  endfunction

  // Reference gating: pass where forward lane > 0, else zero (or grad >>> 3 when leaky).
  function automatic logic [63:0] model(input logic [63:0] f, input logic [63:0] g);
    logic [63:0] r;
    for (int i = 0; i < LANES; i++) begin
      logic signed [15:0] fv;
      logic signed [15:0] gv;
      logic signed [15:0] lv;
      fv = f[i*16 +: 16];
      gv = g[i*16 +: 16];
      lv = gv >>> 3;
      if (fv > 16'sd0) r[i*16 +: 16] = gv;
      else             r[i*16 +: 16] = LEAKY ? lv : 16'sd0;
    end
    return r;
  endfunction

  function automatic logic [63:0] fwd_vec(input int k);
    logic [63:0] r;
    int m;
    int v;
    m = (k * 7 + 5) % 16;
    for (int i = 0; i < LANES; i++) begin
      if (((m >> i) & 1) == 1)     v = k * 10 + i + 1;
      else if ((k + i) % 3 == 0)   v = 0;
      else if ((k + i) % 3 == 1)   v = -(k + i + 1);
      else                         v = -32768;
      r[i*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  function automatic logic [63:0] grad_vec(input int k);
    logic [63:0] r;
    int v;
    for (int i = 0; i < LANES; i++) begin
      v = k * 100 + i * 7 + 9;
      if (i % 2 == 1) v = -v;
      r[i*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic push_fwd(input logic [63:0] d);
    bit done;
    done      = 1'b0;
    fwd_valid = 1'b1;
    fwd_data  = d;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (fwd_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    fwd_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got fwd_ready=0 for 50 cycles, expected 1");
    end else begin
      $display("fwd  push %h", d);
    end
  endtask

  task automatic send_grad(input logic [63:0] g, input logic [63:0] expv);
    bit done;
    done          = 1'b0;
    grad_in_valid = 1'b1;
    grad_in_data  = g;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (grad_in_ready) begin
        done = 1'b1;
        exp_q.push_back(expv);
      end
      @(posedge clk);
      #1;
    end
    grad_in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL grad_timeout: got grad_in_ready=0 for 50 cycles, expected 1");
    end else begin
      $display("grad in   %h", g);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && grad_out_valid && grad_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grad_out_unexpected: got %h, expected no beat", grad_out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("grad_out", grad_out_data, mon_exp);
        $display("grad out  %h", grad_out_data);
      end
    end
  end

  logic [63:0] exp_a;
  logic [63:0] exp_b;

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    fwd_valid      = 1'b0;
    fwd_data       = '0;
    grad_in_valid  = 1'b0;
    grad_in_data   = '0;
    grad_out_ready = 1'b1;

    #2;
    check("rst_fwd_ready", fwd_ready, 1);
    check("rst_grad_in_ready", grad_in_ready, 0);
    check("rst_out_valid", grad_out_valid, 0);
    check("rst_out_data", grad_out_data, 0);
    check("rst_mask_count", mask_count, 0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic gating
    push_fwd(pack4(5, -3, 0, 32767));
    @(negedge clk);
    check("basic_count_after_push", mask_count, 1);
    @(posedge clk);
    #1;
    send_grad(pack4(100, 200, 300, 400),
              LEAKY ? pack4(100, 25, 37, 400) : pack4(100, 0, 0, 400));
    @(negedge clk);
    check("basic_latency_valid", grad_out_valid, 1);
    check("basic_count_after_pop", mask_count, 0);
    @(posedge clk);
    #1;

    // Empty FIFO: gradient must stall
    grad_in_valid = 1'b1;
    grad_in_data  = pack4(1, 2, 3, 4);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("empty_grad_in_ready", grad_in_ready, 0);
      check("empty_out_valid", grad_out_valid, 0);
      @(posedge clk);
      #1;
    end
    grad_in_valid = 1'b0;

    // Ordering across pointer wrap with interleaved pops
    for (int k = 0; k < 4; k++) push_fwd(fwd_vec(k));
    for (int k = 4; k < DEPTH + 4; k++) begin
      push_fwd(fwd_vec(k));
      send_grad(grad_vec(k - 4), model(fwd_vec(k - 4), grad_vec(k - 4)));
    end
    for (int k = DEPTH; k < DEPTH + 4; k++) begin
      send_grad(grad_vec(k), model(fwd_vec(k), grad_vec(k)));
    end
    @(posedge clk);
    #1;

    // Full
    for (int k = 20; k < 20 + DEPTH; k++) push_fwd(fwd_vec(k));
    @(negedge clk);
    check("full_fwd_ready", fwd_ready, 0);
    check("full_mask_count", mask_count, 16);
    @(posedge clk);
    #1;
    fwd_valid = 1'b1;
    fwd_data  = pack4(9, 9, 9, 9);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("full_no_overwrite_count", mask_count, 16);
      @(posedge clk);
      #1;
    end
    fwd_valid = 1'b0;
    for (int k = 20; k < 20 + DEPTH; k++) begin
      send_grad(grad_vec(k), model(fwd_vec(k), grad_vec(k)));
    end
    @(posedge clk);
    #1;

    // Backpressure
    exp_a = LEAKY ? pack4(10, 20, 3, 40)   : pack4(10, 20, 0, 40);
    exp_b = LEAKY ? pack4(-7, 60, -70, 80) : pack4(0, 60, -70, 80);
    push_fwd(pack4(1, 1, -1, 1));
    push_fwd(pack4(-1, 1, 1, 1));
    grad_out_ready = 1'b0;
    send_grad(pack4(10, 20, 30, 40), exp_a);
    grad_in_valid = 1'b1;
    grad_in_data  = pack4(-50, 60, -70, 80);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("bp_out_valid", grad_out_valid, 1);
      check("bp_out_data", grad_out_data, exp_a);
      check("bp_grad_in_ready", grad_in_ready, 0);
      check("bp_mask_count", mask_count, 1);
      @(posedge clk);
      #1;
    end
    grad_out_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_ready", grad_in_ready, 1);
    if (grad_in_ready) exp_q.push_back(exp_b);
    @(posedge clk);
    #1;
    grad_in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // Flush coincident with push and pop
    push_fwd(pack4(1, 2, 3, 4));
    push_fwd(pack4(5, 6, 7, 8));
    push_fwd(pack4(-1, -2, -3, -4));
    flush         = 1'b1;
    fwd_valid     = 1'b1;
    fwd_data      = pack4(11, 12, 13, 14);
    grad_in_valid = 1'b1;
    grad_in_data  = pack4(21, 22, 23, 24);
    @(negedge clk);
    check("flush_pre_count", mask_count, 3);
    @(posedge clk);
    #1;
    flush         = 1'b0;
    fwd_valid     = 1'b0;
    grad_in_valid = 1'b0;
    @(negedge clk);
    check("flush_mask_count", mask_count, 0);
    check("flush_out_valid", grad_out_valid, 0);
    check("flush_grad_in_ready", grad_in_ready, 0);
    @(posedge clk);
    #1;

    // Leaky-derivative vector
    push_fwd(pack4(-1, -1, 2, -8));
    send_grad(pack4(64, -64, 64, -1),
              LEAKY ? pack4(8, -8, 64, -1) : pack4(0, 0, 64, 0));
    @(posedge clk);
    #1;

    // Asynchronous reset mid-stream with a beat pending
    push_fwd(pack4(3, 3, 3, 3));
    push_fwd(pack4(4, 4, 4, 4));
    grad_out_ready = 1'b0;
    send_grad(pack4(7, 7, 7, 7), pack4(7, 7, 7, 7));
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", grad_out_valid, 0);
    check("arst_out_data", grad_out_data, 0);
    check("arst_mask_count", mask_count, 0);
    check("arst_fwd_ready", fwd_ready, 1);
    check("arst_grad_in_ready", grad_in_ready, 0);
    exp_q.delete();
    grad_out_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Normal operation after reset
    push_fwd(pack4(-5, 6, 0, 1));
    send_grad(pack4(-8, -9, 10, 11),
              LEAKY ? pack4(-1, -9, 1, 11) : pack4(0, -9, 0, 11));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
